// File: rtl/bus_master_if_if.sv
// System-bus signal bundle between a bus master and the arbiter / slave mux.
interface bus_master_if_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 30
) ();
  logic              bus_req;
  logic              bus_grnt;
  logic              bus_as;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_ready;

  modport master (
    output bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt, s_rd_data, s_ready
  );

  modport slave (
    input  bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt, s_rd_data, s_ready
  );
endinterface

// File: rtl/bus_master_if.sv
// Master-side bus interface: arbitrates for the system bus on behalf of a
// pipeline stage, runs one access at a time and stalls the pipeline until the
// slave answers or the access times out.
module bus_master_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_err,
  bus_master_if_if.master   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              done;

  assign bus.bus_req     = req_q;
  assign bus.bus_as      = as_q;
  assign bus.bus_rw      = rw_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wd_q;

  // State and bus-side registers; reset drops the bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      as_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      as_q     <= as_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // Next-state, next bus values and combinational pipeline-side outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    as_d        = as_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    rd_buf_d    = rd_buf_q;
    done        = 1'b0;
    cpu_busy    = 1'b0;
    cpu_rd_data = '0;
    cpu_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && !flush) begin
          cpu_busy = 1'b1;
          rw_d     = cpu_rw;
          addr_d   = cpu_addr;
          wd_d     = cpu_wr_data;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end

      REQ: begin
        cpu_busy = 1'b1;
        if (flush) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.bus_grnt) begin
          as_d    = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // flush is deliberately ignored here: a started bus cycle always ends.
        if (bus.s_ready) begin
          cpu_rd_data = rw_q ? bus.s_rd_data : '0;
          rd_buf_d    = cpu_rd_data;
          done        = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cpu_err  = 1'b1;
          rd_buf_d = '0;
          done     = 1'b1;
        end else begin
          cpu_busy = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
        if (done) begin
          req_d   = 1'b0;
          as_d    = 1'b0;
          state_d = stall ? STALL : IDLE;
        end
      end

      STALL: begin
        cpu_rd_data = rd_buf_q;
        if (!stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side bus interface between a CPU pipeline stage (instruction fetch or memory access) and the shared system bus.
- Requests bus ownership from the arbiter and drives address, strobe, R/W and write data.
- Consumes the selected slave's read data and ready (s_rd_data, s_ready) produced by the slave multiplexer.
- Stalls the pipeline until the access completes or times out.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 30, word-address width
TIMEOUT, 255, maximum ACCESS cycles without s_ready before abort (1..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  access request from pipeline
cpu_rw  in  1  1=read, 0=write
cpu_addr  in  ADDR_W  word address
cpu_wr_data  in  DATA_W  write data
stall  in  1  pipeline stall
flush  in  1  pipeline flush
cpu_busy  out  1  stall request to pipeline
cpu_rd_data  out  DATA_W  read data to pipeline
cpu_err  out  1  one-cycle bus-timeout pulse
bus_req  out  1  ownership request to arbiter
bus_grnt  in  1  grant from arbiter
bus_as  out  1  address strobe, active high
bus_rw  out  1  1=read, 0=write
bus_addr  out  ADDR_W  bus address
bus_wr_data  out  DATA_W  bus write data
s_rd_data  in  DATA_W  read data from slave mux
s_ready  in  1  ready from slave mux

Behaviour:
- One clock domain (clk). reset_n is asynchronous and active-low.
- Reset values: state=IDLE; bus_req, bus_as, bus_rw, bus_addr, bus_wr_data, counter and rd_buf all 0.
- Reset is honoured mid-transaction: bus_req and bus_as drop immediately, with no completion and no error.
- bus_* outputs are registered. cpu_busy, cpu_rd_data and cpu_err are combinational from state and inputs.
- Completion in ACCESS (s_ready=1, or timeout) clears bus_req and bus_as at the next edge. Next state is STALL if stall=1, else IDLE.

State IDLE:
- If cpu_req & !flush: cpu_busy=1. Next edge: latch cpu_addr/cpu_rw/cpu_wr_data into bus_addr/bus_rw/bus_wr_data, set bus_req=1, go to REQ.
- Otherwise: cpu_busy=0, cpu_rd_data=0.

State REQ:
- cpu_busy=1.
- If flush=1: next edge clears bus_req and returns to IDLE; no bus cycle is issued. flush has priority over bus_grnt in the same cycle.
- Else if bus_grnt=1: next edge sets bus_as=1, clears counter, goes to ACCESS.

State ACCESS:
- bus_as, bus_addr, bus_rw and bus_wr_data are held stable, so the slave chip-select stays valid.
- flush is ignored; the access always completes.
- If s_ready=1: cpu_busy=0 this cycle. cpu_rd_data = s_rd_data on a read, 0 on a write. Next edge latches that value into rd_buf and completes.
- Else if counter == TIMEOUT-1: cpu_busy=0, cpu_err=1, cpu_rd_data=0 this cycle. Next edge sets rd_buf=0 and completes.
- Else: cpu_busy=1, counter increments.
- s_ready wins over timeout when both occur in the same cycle.

State STALL:
- cpu_busy=0, cpu_rd_data=rd_buf.
- When stall=0: go to IDLE.
- No new request is accepted while in STALL.

Latency:
- Request cycle t → bus_req high at t+1.
- First grant cycle g → bus_as high at g+1.
- A zero-wait slave (s_ready in the first ACCESS cycle) gives 3-cycle minimum occupancy with immediate grant.

Other rules:
- cpu_err is high only in the timeout cycle.
- Only one transaction is outstanding; there is no pipelining of requests.

Test Plan:
- Read, immediate grant, zero-wait slave (addr=0x0000_0010, s_rd_data=0xDEAD_BEEF) → bus_req at t+1, bus_as at t+2, cpu_busy low at t+2, cpu_rd_data=0xDEAD_BEEF in that cycle, bus_req=bus_as=0 at t+3.
- Write with grant delayed 4 cycles and 2 wait states (wr_data=0x1234_5678) → bus_addr/bus_wr_data stable from t+1 to completion, cpu_busy high throughout, cpu_rd_data=0 at completion.
- Read completes with stall=1 for 3 cycles → state STALL, cpu_rd_data holds the read value for 3 cycles, cpu_busy=0, no new bus_req until stall drops.
- flush asserted in REQ together with bus_grnt=1 → bus_req drops next edge, bus_as never asserts, state IDLE.
- Slave never readies (TIMEOUT=4) → cpu_err=1 and cpu_busy=0 in the 4th ACCESS cycle, cpu_rd_data=0, bus idle next cycle. Repeat with s_ready=1 in the 4th cycle → no cpu_err, data delivered.
- reset_n pulsed low mid-ACCESS between clock edges → all bus_* outputs 0 immediately, state IDLE, cpu_err never pulses.
